aes_bram_block_sequencer: RTL and testbench

// - Datapath stage below the AES AXI4-Lite register slave. Takes start, source/dest word addresses and a block count from that slave.
// - Reads 128-bit blocks from BRAM as four 32-bit words, passes each block to the AES core over valid/ready, and writes the result back to BRAM.
// - Reports busy, a done pulse and a completed-block count back to the register slave for status readback.

---
 rtl/aes_bram_block_sequencer.sv | 144 ++++++++++++++
 tb/tb_aes_bram_block_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_bram_block_sequencer.sv
// rtl/aes_bram_block_sequencer.sv - BRAM-to-AES block sequencer: read 4 words, hand block to core, write result back.
// Optional: AES_BRAM_SEQ_BYTESWAP_EN byte-reverses every BRAM word on read and on write.
module aes_bram_block_sequencer #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]  num_blocks,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  blocks_done,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata,
    output logic              aes_in_valid,
    input  logic              aes_in_ready,
    output logic [127:0]      aes_in_data,
    input  logic              aes_out_valid,
    output logic              aes_out_ready,
    input  logic [127:0]      aes_out_data
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_WAIT, S_SEND, S_RECV, S_WR, S_FIN} state_t;

    state_t            r_state, w_next;
    logic [1:0]        r_k;
    logic [ADDR_W-1:0] r_src, r_dst;
    logic [CNT_W-1:0]  r_num, r_blocks_done;
    logic              r_busy, r_done;
    logic [31:0]       r_in_w  [4];
    logic [31:0]       r_res_w [4];

    logic [ADDR_W-1:0] w_blk_off, w_k_off;
    logic              w_more;
    logic              w_capture;
    logic [1:0]        w_cap_idx;

    function automatic logic [31:0] f_swap(input logic [31:0] w);
`ifdef AES_BRAM_SEQ_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    assign w_blk_off = ADDR_W'({r_blocks_done, 2'b00});
    assign w_k_off   = {{(ADDR_W-2){1'b0}}, r_k};
    assign w_more    = (r_blocks_done + CNT_W'(1)) < r_num;
    // Read data lags the address by one cycle; r_k has wrapped to 0 in RD_WAIT, so k-1 selects word 3.
    assign w_capture = (r_state == S_RD && r_k != 2'd0) || (r_state == S_RD_WAIT);
    assign w_cap_idx = r_k - 2'd1;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_src         <= '0;
            r_dst         <= '0;
            r_num         <= '0;
            r_blocks_done <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_in_w[i]  <= '0;
                r_res_w[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: if (start) begin
                    r_src         <= src_base;
                    r_dst         <= dst_base;
                    r_num         <= num_blocks;
                    r_blocks_done <= '0;
                    r_busy        <= (num_blocks != '0);
                    r_k           <= '0;
                end
                S_RD: r_k <= r_k + 2'd1;
                S_RECV: if (aes_out_valid) begin
                    r_res_w[0] <= aes_out_data[127:96];
                    r_res_w[1] <= aes_out_data[95:64];
                    r_res_w[2] <= aes_out_data[63:32];
                    r_res_w[3] <= aes_out_data[31:0];
                end
                S_WR: begin
                    r_k <= r_k + 2'd1;
                    if (r_k == 2'd3) r_blocks_done <= r_blocks_done + CNT_W'(1);
                end
                S_FIN: r_busy <= 1'b0;
                default: ;
            endcase
            if (w_capture) r_in_w[w_cap_idx] <= f_swap(bram_rdata);
        end
    end

    always_comb begin
        w_next        = r_state;
        bram_en       = 1'b0;
        bram_we       = 4'h0;
        bram_addr     = '0;
        bram_wdata    = '0;
        aes_in_valid  = 1'b0;
        aes_out_ready = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = (num_blocks == '0) ? S_FIN : S_RD;
            S_RD: begin
                bram_en   = 1'b1;
                bram_addr = r_src + w_blk_off + w_k_off;
                if (r_k == 2'd3) w_next = S_RD_WAIT;
            end
            S_RD_WAIT: w_next = S_SEND;
            S_SEND: begin
                aes_in_valid = 1'b1;
                if (aes_in_ready) w_next = S_RECV;
            end
            S_RECV: begin
                aes_out_ready = 1'b1;
                if (aes_out_valid) w_next = S_WR;
            end
            S_WR: begin
                bram_en    = 1'b1;
                bram_we    = 4'hF;
                bram_addr  = r_dst + w_blk_off + w_k_off;
                bram_wdata = f_swap(r_res_w[r_k]);
                if (r_k == 2'd3) w_next = w_more ? S_RD : S_FIN;
            end
            S_FIN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign blocks_done = r_blocks_done;
    assign aes_in_data = {r_in_w[0], r_in_w[1], r_in_w[2], r_in_w[3]};

endmodule

// File: tb/tb_aes_bram_block_sequencer.sv
// tb/tb_aes_bram_block_sequencer.sv - randomized bench with BRAM, AES stub and job-level reference model.
module tb_aes_bram_block_sequencer;

    logic         ACLK = 1'b0;
    logic         ARESET, start;
    logic [9:0]   src_base, dst_base;
    logic [15:0]  num_blocks;
    logic         busy, done;
    logic [15:0]  blocks_done;
    logic         bram_en;
    logic [3:0]   bram_we;
    logic [9:0]   bram_addr;
    logic [31:0]  bram_wdata, bram_rdata;
    logic         aes_in_valid, aes_in_ready;
    logic [127:0] aes_in_data;
    logic         aes_out_valid, aes_out_ready;
    logic [127:0] aes_out_data;

    aes_bram_block_sequencer #(.ADDR_W(10), .CNT_W(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start),
        .src_base(src_base), .dst_base(dst_base), .num_blocks(num_blocks),
        .busy(busy), .done(done), .blocks_done(blocks_done),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .aes_in_valid(aes_in_valid), .aes_in_ready(aes_in_ready), .aes_in_data(aes_in_data),
        .aes_out_valid(aes_out_valid), .aes_out_ready(aes_out_ready), .aes_out_data(aes_out_data)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    logic busy_seen = 1'b0, en_seen = 1'b0, rnd_rdy = 1'b0;

    logic [31:0]  mem     [1024];
    logic [31:0]  exp_mem [1024];
    logic [9:0]   q_rd[$];
    logic [127:0] q_in[$];
    logic [9:0]   q_wa[$];
    logic [31:0]  q_wd[$];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef AES_BRAM_SEQ_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Core stand-in: FIPS-197 known answer for the reference plaintext, bitwise inversion otherwise.
    function automatic logic [127:0] aes_f(input logic [127:0] x);
        if (x == 128'h00112233445566778899aabbccddeeff) return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        return ~x;
    endfunction

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(posedge ACLK) begin
        if (bram_en) begin
            if (bram_we == 4'hF) mem[bram_addr] = bram_wdata;
            else bram_rdata <= mem[bram_addr];
        end
    end

    int st = 0, dly = 0;
    logic [127:0] hold;
    always @(posedge ACLK) begin
        if (ARESET) begin
            st <= 0; dly <= 0; aes_in_ready <= 1'b0; aes_out_valid <= 1'b0; aes_out_data <= '0;
        end else begin
            case (st)
                0: if (aes_in_valid && aes_in_ready) begin
                    hold <= aes_f(aes_in_data); dly <= int'($urandom % 4); st <= 1; aes_in_ready <= 1'b0;
                end else aes_in_ready <= rnd_rdy ? ($urandom % 2 == 1) : 1'b1;
                1: if (dly == 0) begin aes_out_valid <= 1'b1; aes_out_data <= hold; st <= 2; end
                   else dly <= dly - 1;
                default: if (aes_out_ready) begin aes_out_valid <= 1'b0; st <= 0; end
            endcase
        end
    end

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (busy) busy_seen = 1'b1;
            if (bram_en) en_seen = 1'b1;
            if (bram_en && bram_we == 4'h0) begin
                if (q_rd.size() == 0) chk("unexpected_read", {118'd0, bram_addr}, 128'hx);
                else chk("rd_addr", bram_addr, q_rd.pop_front());
            end else if (bram_en && bram_we == 4'hF) begin
                if (q_wa.size() == 0) chk("unexpected_write", {118'd0, bram_addr}, 128'hx);
                else begin
                    chk("wr_addr", bram_addr, q_wa.pop_front());
                    chk("wr_data", bram_wdata, q_wd.pop_front());
                end
            end else if (bram_en) chk("bram_we", bram_we, 4'hF);
            if (aes_in_valid && aes_in_ready) begin
                if (q_in.size() == 0) chk("unexpected_aes_in", aes_in_data, 128'hx);
                else chk("aes_in_data", aes_in_data, q_in.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 1'b0);
            end
        end
    end

    // Job-level model: blocks processed strictly in order, each fully read before its writeback.
    task automatic start_job(input logic [9:0] s, input logic [9:0] d, input logic [15:0] n);
        logic [127:0] blk, r;
        logic [9:0] a;
        for (int i = 0; i < 1024; i++) exp_mem[i] = mem[i];
        for (int b = 0; b < int'(n); b++) begin
            blk = '0;
            for (int k = 0; k < 4; k++) begin
                a = s + 10'(4 * b + k);
                q_rd.push_back(a);
                blk = {blk[95:0], sw(exp_mem[a])};
            end
            q_in.push_back(blk);
            r = aes_f(blk);
            for (int k = 0; k < 4; k++) begin
                a = d + 10'(4 * b + k);
                q_wa.push_back(a);
                q_wd.push_back(sw(r[127:96]));
                exp_mem[a] = sw(r[127:96]);
                r = r << 32;
            end
        end
        @(negedge ACLK);
        start = 1'b1; src_base = s; dst_base = d; num_blocks = n; start_cyc = cyc;
        @(negedge ACLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input logic [15:0] n, input bit interfere);
        int d0, t, bad;
        d0 = done_cnt - ((done && start_cyc + 1 == cyc) ? 1 : 0);
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge ACLK);
            t++;
            if (interfere && t == 6) begin
                start = 1'b1; src_base = 10'h155; dst_base = 10'h000; num_blocks = 16'd7;
            end else if (interfere && t == 7) start = 1'b0;
        end
        chk({nm, "_done_timeout"}, t < 3000, 1'b1);
        repeat (3) @(negedge ACLK);
        chk({nm, "_done_pulses"}, done_cnt - d0, 1);
        chk({nm, "_blocks_done"}, blocks_done, n);
        chk({nm, "_busy_after"}, busy, 1'b0);
        chk({nm, "_queues_left"}, q_rd.size() + q_in.size() + q_wa.size(), 0);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk({nm, "_mem_image"}, bad, 0);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_done"}, done, 1'b0);
        chk({nm, "_blocks_done"}, blocks_done, 16'd0);
        chk({nm, "_bram_en"}, bram_en, 1'b0);
        chk({nm, "_bram_we"}, bram_we, 4'h0);
        chk({nm, "_bram_addr"}, bram_addr, 10'h0);
        chk({nm, "_bram_wdata"}, bram_wdata, 32'h0);
        chk({nm, "_aes_in_valid"}, aes_in_valid, 1'b0);
        chk({nm, "_aes_out_ready"}, aes_out_ready, 1'b0);
        chk({nm, "_aes_in_data"}, aes_in_data, 128'h0);
    endtask

    initial begin
        int t, d0;
        ARESET = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; num_blocks = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        repeat (3) @(negedge ACLK);
        chk_quiet("reset");
        ARESET = 1'b0;

        mem[0] = 32'h00112233; mem[1] = 32'h44556677; mem[2] = 32'h8899aabb; mem[3] = 32'hccddeeff;
`ifdef AES_BRAM_SEQ_BYTESWAP_EN
        for (int i = 0; i < 4; i++) mem[i] = sw(mem[i]);
`endif
        start_job(10'h000, 10'h040, 16'd1);
        wait_done("fips", 16'd1, 1'b0);
`ifndef AES_BRAM_SEQ_BYTESWAP_EN
        chk("fips_w0", mem[10'h40], 32'h69c4e0d8);
        chk("fips_w1", mem[10'h41], 32'h6a7b0430);
        chk("fips_w2", mem[10'h42], 32'hd8cdb780);
        chk("fips_w3", mem[10'h43], 32'h70b4c55a);
`endif

        busy_seen = 1'b0; en_seen = 1'b0;
        start_job(10'h123, 10'h321, 16'd0);
        wait_done("zero", 16'd0, 1'b0);
        chk("zero_done_latency", done_cyc - start_cyc, 2);
        chk("zero_busy_seen", busy_seen, 1'b0);
        chk("zero_bram_en_seen", en_seen, 1'b0);

        rnd_rdy = 1'b1;
        mem[10'h100] = 32'h12345678;
        start_job(10'h100, 10'h200, 16'd3);
        wait_done("three", 16'd3, 1'b0);
        chk("three_lit", mem[10'h200], 32'hedcba987);

        mem[10'h000] = 32'hA5A50000;
        start_job(10'h3FC, 10'h3FC, 16'd2);
        wait_done("wrap", 16'd2, 1'b0);
        chk("wrap_lit", mem[10'h000], 32'h5a5affff);

        start_job(10'h050, 10'h0A0, 16'd3);
        wait_done("ignore_start", 16'd3, 1'b1);

        start_job(10'h080, 10'h180, 16'd4);
        t = 0;
        while (!(blocks_done == 16'd1 && bram_we == 4'hF) && t < 500) begin
            @(negedge ACLK);
            t++;
        end
        chk("abort_reach_wr1", t < 500, 1'b1);
        d0 = done_cnt;
        ARESET = 1'b1;
        @(negedge ACLK);
        chk_quiet("abort");
        q_rd.delete(); q_in.delete(); q_wa.delete(); q_wd.delete();
        ARESET = 1'b0;
        repeat (30) @(negedge ACLK);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_idle_busy", busy, 1'b0);

        start_job(10'h080, 10'h180, 16'd2);
        wait_done("after_abort", 16'd2, 1'b0);

        for (int j = 0; j < 4; j++) begin
            start_job(10'($urandom), 10'($urandom), 16'($urandom_range(1, 4)));
            wait_done("rand", num_blocks, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
